// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential multiply-accumulate FIR stage fed by the sample circular buffer
//
// Each burst of `sequencing` multiplies the streamed samples by coefficients
// read from an external 1-cycle-latency ROM. The products are summed and one
// saturated result is emitted when the burst ends.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sequencing  high while smpl_in carries a valid buffer sample
//   smpl_in     signed 16-bit sample, valid with sequencing
//   coeff_addr  coefficient ROM read address (tap index)
//   coeff       signed 16-bit coefficient, one cycle after coeff_addr
//   smpl_out    signed 16-bit filtered result, held until the next result
//   smpl_vld    one-cycle pulse when smpl_out updates
module fir_mac_seq #(
  parameter int TAPS = 1024,
  parameter int AW   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sequencing,
  input  logic signed [15:0] smpl_in,
  output logic [AW-1:0]      coeff_addr,
  input  logic signed [15:0] coeff,
  output logic signed [15:0] smpl_out,
  output logic               smpl_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [AW:0]        tap_cnt;     // taps issued so far this burst; reaches TAPS
  logic [AW-1:0]      addr_q;      // address of the next tap, saturated at TAPS-1
  logic               drain_cnt;
  logic signed [15:0] s1_smpl;
  logic               s1_vld;
  logic signed [31:0] p2_prod;
  logic               p2_vld;
  logic signed [41:0] acc;

  logic               issue;
  logic [AW:0]        tap_cnt_nxt;
  logic signed [41:0] acc_shr;
  logic signed [15:0] sat_val;

  // Tap count is always zero in IDLE, so one limit test covers both states.
  assign issue       = sequencing && (state != DRAIN) && (tap_cnt < (AW+1)'(TAPS));
  assign tap_cnt_nxt = tap_cnt + 1'b1;

  // The cycle sequencing drops is already the first drain cycle, although the
  // state register only moves to DRAIN at the end of it. Gating with
  // sequencing makes the ROM address return to 0 in that same cycle.
  assign coeff_addr  = (state == ACCUM && sequencing) ? addr_q : '0;

  assign acc_shr = acc >>> 15;

  always_comb begin
    sat_val = acc_shr[15:0];
    if (acc_shr > 42'sd32767) begin
      sat_val = 16'sh7fff;
    end else if (acc_shr < -42'sd32768) begin
      sat_val = 16'sh8000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      addr_q    <= '0;
      drain_cnt <= 1'b0;
      s1_smpl   <= '0;
      s1_vld    <= 1'b0;
      p2_prod   <= '0;
      p2_vld    <= 1'b0;
      acc       <= '0;
      smpl_out  <= '0;
      smpl_vld  <= 1'b0;
    end else begin
      smpl_vld <= 1'b0;

      // Stage 1: sample waits here while the ROM returns its coefficient.
      s1_vld <= issue;
      if (issue) begin
        s1_smpl <= smpl_in;
      end

      // Stage 2: registered product.
      p2_vld <= s1_vld;
      if (s1_vld) begin
        p2_prod <= 32'(s1_smpl) * 32'(coeff);
      end

      // Stage 3: accumulate.
      if (p2_vld) begin
        acc <= acc + 42'(p2_prod);
      end

      if (issue) begin
        tap_cnt <= tap_cnt_nxt;
        addr_q  <= (tap_cnt_nxt >= (AW+1)'(TAPS)) ? AW'(TAPS - 1) : tap_cnt_nxt[AW-1:0];
      end

      case (state)
        IDLE: begin
          if (sequencing) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (!sequencing) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
            tap_cnt   <= '0;
            addr_q    <= '0;
          end
        end
        DRAIN: begin
          // Two cycles here plus the ACCUM cycle that saw sequencing low
          // give the three cycles needed for the last product to land.
          if (drain_cnt) begin
            state    <= IDLE;
            smpl_out <= sat_val;
            smpl_vld <= 1'b1;
            acc      <= '0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
